// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction-fetch stage. Issues one word read per PC to
//                instruction memory (req/ready + rvalid), registers the
//                returned instruction, predecodes its fields and pulses
//                pc_enable once per executed instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int TIMEOUT   = 255,  // max WAIT cycles before a fetch error
    parameter int TIMEOUT_W = 8,    // wait-counter width, 2**TIMEOUT_W > TIMEOUT
    parameter int CNT_W     = 32    // retired-fetch counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [25:0]      jea,
    output logic [31:0]      imm_sign_extend,
    output logic             is_nop,
    output logic             pc_enable,
    output logic             fetch_error,
    output logic [CNT_W-1:0] fetch_count
);

    // State encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_hold  = 3'd4;
    localparam logic [2:0] c_st_error = 3'd5;

    localparam logic [TIMEOUT_W-1:0] c_timeout_cnt = TIMEOUT_W'(TIMEOUT);

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [31:0]          r_instr;
    logic [31:0]          w_instr_next;
    logic                 r_instr_valid;
    logic                 w_instr_valid_next;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic [TIMEOUT_W-1:0] w_wait_cnt_next;
    logic [TIMEOUT_W-1:0] w_wait_cnt_inc;
    logic [CNT_W-1:0]     r_fetch_count;
    logic [CNT_W-1:0]     w_fetch_count_next;

    assign w_wait_cnt_inc = r_wait_cnt + TIMEOUT_W'(1);

    // State register and datapath registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_wait_cnt    <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    // Next-state and register-update logic; rvalid outside WAIT is dropped
    always_comb begin
        w_state_next       = r_state;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        w_wait_cnt_next    = r_wait_cnt;
        w_fetch_count_next = r_fetch_count;

        case (r_state)
            c_st_idle: begin
                w_state_next = c_st_req;
            end
            c_st_req: begin
                // A misaligned PC wins over a same-cycle ready
                if (pc[1:0] != 2'b00) begin
                    w_state_next = c_st_error;
                end else if (mem_ready) begin
                    w_state_next    = c_st_wait;
                    w_wait_cnt_next = '0;
                end
            end
            c_st_wait: begin
                w_wait_cnt_next = w_wait_cnt_inc;
                // rvalid wins over a coincident timeout
                if (mem_rvalid) begin
                    w_instr_next       = mem_rdata;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = stall ? c_st_hold : c_st_exec;
                end else if (w_wait_cnt_inc == c_timeout_cnt) begin
                    w_state_next = c_st_error;
                end
            end
            c_st_exec: begin
                w_fetch_count_next = r_fetch_count + CNT_W'(1);
                w_state_next       = c_st_req;
            end
            c_st_hold: begin
                if (!stall) begin
                    w_state_next = c_st_exec;
                end
            end
            c_st_error: begin
                w_state_next = c_st_error;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Outputs decode from state and registers only (predecode from instr)
    always_comb begin
        mem_req         = (r_state == c_st_req);
        mem_addr        = mem_req ? pc : 32'h0;
        pc_enable       = (r_state == c_st_exec);
        fetch_error     = (r_state == c_st_error);
        instr           = r_instr;
        instr_valid     = r_instr_valid & (r_state != c_st_error);
        jea             = r_instr[25:0];
        imm_sign_extend = {{16{r_instr[15]}}, r_instr[15:0]};
        is_nop          = ~instr_valid | (r_instr == 32'h0);
        fetch_count     = r_fetch_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. The bench plays
//                memory and PC controller and predicts each fetch at the
//                transaction level (fixed cycle offsets from handshake events,
//                predecode by plain arithmetic on the returned word).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int TIMEOUT   = 4;
    localparam int TIMEOUT_W = 3;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      pc;
    logic             stall;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ready;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic [31:0]      instr;
    logic             instr_valid;
    logic [25:0]      jea;
    logic [31:0]      imm_sign_extend;
    logic             is_nop;
    logic             pc_enable;
    logic             fetch_error;
    logic [CNT_W-1:0] fetch_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instr;
    logic        exp_valid;
    int          exp_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .stall           (stall),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .jea             (jea),
        .imm_sign_extend (imm_sign_extend),
        .is_nop          (is_nop),
        .pc_enable       (pc_enable),
        .fetch_error     (fetch_error),
        .fetch_count     (fetch_count)
    );

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req), 32'h0);
        check({tag, "_addr"},  mem_addr, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_pe"},    32'(pc_enable), 32'h0);
        check({tag, "_err"},   32'(fetch_error), 32'h0);
        check({tag, "_cnt"},   fetch_count, 32'h0);
        check({tag, "_nop"},   32'(is_nop), 32'h1);
        check({tag, "_jea"},   32'(jea), 32'h0);
        check({tag, "_imm"},   imm_sign_extend, 32'h0);
    endtask

    // Reference expectation for one full fetch, starting in a REQ cycle.
    task automatic fetch_one(input int rdy_dly, input int rv_dly, input int stall_n,
                             input logic [31:0] data, input logic [31:0] next_pc);
        logic signed [15:0] half;
        logic [31:0]        exp_imm;
        logic [31:0]        exp_jea;
        half    = data[15:0];
        exp_imm = 32'(int'(half));
        exp_jea = data % 32'h0400_0000;

        check("req_start", 32'(mem_req), 32'h1);
        check("req_addr", mem_addr, pc);
        check("req_valid", 32'(instr_valid), 32'(exp_valid));
        check("req_nop", 32'(is_nop), 32'((!exp_valid) || (exp_instr == 32'h0)));

        // Memory not ready: request and address must be held
        for (int i = 0; i < rdy_dly; i++) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom();
            tick();
            mem_rvalid = 1'b0;
            check("hold_req", 32'(mem_req), 32'h1);
            check("hold_addr", mem_addr, pc);
            check("hold_pe", 32'(pc_enable), 32'h0);
            check("hold_drop", instr, exp_instr);
        end

        // Accept, with a stray rvalid that must be ignored
        mem_ready  = 1'b1;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom();
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;

        for (int i = 0; i < rv_dly; i++) begin
            check("wait_req", 32'(mem_req), 32'h0);
            check("wait_pe", 32'(pc_enable), 32'h0);
            tick();
        end
        check("wait_req", 32'(mem_req), 32'h0);
        check("wait_err", 32'(fetch_error), 32'h0);
        check("wait_instr", instr, exp_instr);

        mem_rvalid = 1'b1;
        mem_rdata  = data;
        stall      = (stall_n > 0);
        tick();
        mem_rvalid = 1'b0;
        exp_instr  = data;
        exp_valid  = 1'b1;

        for (int i = 0; i < stall_n; i++) begin
            check("stall_pe", 32'(pc_enable), 32'h0);
            check("stall_instr", instr, data);
            check("stall_valid", 32'(instr_valid), 32'h1);
            if (i == stall_n - 1) stall = 1'b0;
            tick();
        end

        // Execute cycle: exactly one pc_enable pulse
        check("exec_pe", 32'(pc_enable), 32'h1);
        check("exec_instr", instr, data);
        check("exec_valid", 32'(instr_valid), 32'h1);
        check("exec_jea", 32'(jea), exp_jea);
        check("exec_imm", imm_sign_extend, exp_imm);
        check("exec_nop", 32'(is_nop), 32'(data == 32'h0));
        check("exec_req", 32'(mem_req), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = ~data;
        tick();
        mem_rvalid = 1'b0;
        exp_count++;

        // PC controller advances on the enabling edge
        pc = next_pc;
        #1;
        check("after_pe", 32'(pc_enable), 32'h0);
        check("after_cnt", fetch_count, 32'(exp_count));
        check("after_instr", instr, data);
        check("after_valid", 32'(instr_valid), 32'h1);
    endtask

    initial begin
        logic [31:0] data;
        logic [31:0] npc;
        logic [31:0] r;

        reset      = 1'b1;
        pc         = 32'h0;
        stall      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        exp_instr  = 32'h0;
        exp_valid  = 1'b0;
        exp_count  = 0;

        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("idle_req", 32'(mem_req), 32'h0);
        tick();

        // Directed fetches
        fetch_one(0, 0, 0, 32'h0800_0010, 32'h4);
        fetch_one(0, 0, 0, 32'h1000_FFFE, 32'h8);
        fetch_one(0, 0, 0, 32'h0000_0000, 32'hC);
        fetch_one(0, 0, 5, 32'h2108_0005, 32'h10);
        fetch_one(3, 0, 0, 32'h8C43_8004, 32'h14);
        fetch_one(0, 3, 0, 32'hAC22_7FFF, 32'h18);

        // Randomized fetches
        for (int n = 0; n < 40; n++) begin
            data = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            if ($urandom_range(0, 3) == 0) begin
                r   = $urandom();
                npc = r & 32'hFFFF_FFFC;
            end else begin
                npc = pc + 32'h4;
            end
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), data, npc);
        end

        // Misaligned PC: error even with ready asserted
        pc = 32'h0000_0006;
        #1;
        check("mis_req", 32'(mem_req), 32'h1);
        check("mis_addr", mem_addr, 32'h0000_0006);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("mis_err", 32'(fetch_error), 32'h1);
        check("mis_req_off", 32'(mem_req), 32'h0);
        check("mis_valid", 32'(instr_valid), 32'h0);
        tick();
        check("mis_sticky", 32'(fetch_error), 32'h1);

        // Reset out of ERROR, then a timeout
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_err");
        reset = 1'b0;
        pc = 32'h0000_0100;
        tick();
        check("to_req", 32'(mem_req), 32'h1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_wait_err", 32'(fetch_error), 32'h0);
            tick();
        end
        check("to_err", 32'(fetch_error), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("to_req_off", 32'(mem_req), 32'h0);
            tick();
        end
        check("to_nop", 32'(is_nop), 32'h1);

        // Clean restart, one fetch, then a reset in the middle of WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc = 32'h0000_0200;
        exp_instr = 32'h0;
        exp_valid = 1'b0;
        exp_count = 0;
        tick();
        fetch_one(0, 1, 0, 32'h0123_4567, 32'h0000_0204);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst_mid");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        exp_instr = 32'h0;
        exp_valid = 1'b0;
        exp_count = 0;
        check("rv_idle_drop", instr, 32'h0);
        check("rv_idle_valid", 32'(instr_valid), 32'h0);
        fetch_one(1, 1, 1, 32'hFFFF_8000, 32'h0000_0208);
        fetch_one(0, 0, 0, 32'h0000_0000, 32'h0000_020C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
